// File: rtl/seven_seg_scanner_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner_if
//   Bundles the digit inputs and the display-side outputs of the 7-segment
//   scanner.
//   master : the datapath side. It drives digits_in/dp_mask/blank_lz and
//            observes seg/dp/an/frame_tick.
//   slave  : the scanner. It consumes the digits and drives the display pins.
//   digits_in  4*NUM_DIGITS  packed BCD, digit k = digits_in[4k+3:4k]
//   dp_mask    NUM_DIGITS    bit k lights the decimal point of digit k
//   blank_lz   1             leading-zero blanking enable
//   seg        7             {g,f,e,d,c,b,a}
//   dp         1             decimal point
//   an         NUM_DIGITS    one-hot digit enable
//   frame_tick 1             one-cycle pulse at the end of each scan frame
// -----------------------------------------------------------------------------
interface seven_seg_scanner_if #(
   parameter int NUM_DIGITS = 6
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic                    blank_lz;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_tick;

   modport master (
      output digits_in, dp_mask, blank_lz,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  digits_in, dp_mask, blank_lz,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed 7-segment driver. The block scans NUM_DIGITS BCD digits
//   one at a time onto a shared segment bus. Each digit slot lasts SCAN_DIV
//   clocks. The first cycle of a slot is dark, which stops the new anode from
//   flashing the previous digit's segments.
//
//   Digits and decimal points are captured into a shadow register only at the
//   end of a frame, so a frame never shows a mix of old and new values.
//   Leading-zero blanking reads blank_lz live and reads the digits from the
//   shadow. Codes A-F display a dash.
//
//   All display outputs are registered and lag the scan state by one clock.
//   The registers hold the polarized pin values, so the reset value is
//   "everything off" at the configured polarity.
//
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous, active-high
//     bus    seven_seg_scanner_if.slave (digits_in, dp_mask, blank_lz in;
//            seg, dp, an, frame_tick out)
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int NUM_DIGITS     = 6,
   parameter int SCAN_DIV       = 100000,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit ACTIVE_LOW_AN  = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   seven_seg_scanner_if.slave        bus
);

   localparam int PW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   // XOR masks that convert the active-high internal values to pin polarity.
   localparam logic [NUM_DIGITS-1:0] AN_INV  = ACTIVE_LOW_AN  ? {NUM_DIGITS{1'b1}} : '0;
   localparam logic [6:0]            SEG_INV = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
   localparam logic                  DP_INV  = ACTIVE_LOW_SEG;

   // Scan state
   logic [PW-1:0]                pre_cnt_q, pre_cnt_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;

   // Registered outputs, already polarized
   logic [NUM_DIGITS-1:0]        an_q, an_d;
   logic [6:0]                   seg_q, seg_d;
   logic                         dp_q, dp_d;
   logic                         tick_q, tick_d;

   logic                         pre_last, idx_last, frame_end;
   logic                         lit;
   logic [3:0]                   cur_digit;
   logic [NUM_DIGITS-1:0]        upper_zero;
   logic                         blank_cur;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;   // non-BCD code: dash on segment g
      endcase
      return s;
   endfunction

   assign pre_last  = (pre_cnt_q == PW'(SCAN_DIV - 1));
   assign idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
   assign frame_end = pre_last && idx_last;

   // Prescaler, digit index and frame-end shadow capture
   always_comb begin
      pre_cnt_d   = pre_cnt_q + PW'(1);
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      if (pre_last) begin
         pre_cnt_d = '0;
         idx_d     = idx_last ? '0 : idx_q + IW'(1);
      end
      if (frame_end) begin
         shadow_d    = bus.digits_in;
         shadow_dp_d = bus.dp_mask;
      end
   end

   // upper_zero[k]: shadow digits k..NUM_DIGITS-1 are all zero.
   // The scan runs from the top digit down and carries the result in an
   // accumulator, so no bit depends on another bit of the same vector.
   always_comb begin
      logic acc;
      acc        = 1'b1;
      upper_zero = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         acc           = acc && (shadow_q[k] == 4'd0);
         upper_zero[k] = acc;
      end
   end

   assign lit       = (pre_cnt_q != '0);
   assign cur_digit = shadow_q[idx_q];
   assign blank_cur = bus.blank_lz && (idx_q != '0) && upper_zero[idx_q];

   // Output next-state. Segments keep the current digit during the dark
   // cycle. Only the anodes and dp are gated there.
   always_comb begin
      an_d   = AN_INV;
      seg_d  = SEG_INV ^ (blank_cur ? 7'h00 : bcd_to_seg(cur_digit));
      dp_d   = DP_INV ^ (lit && shadow_dp_q[idx_q]);
      tick_d = frame_end;
      if (lit)
         an_d = AN_INV ^ (NUM_DIGITS'(1) << idx_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q   <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         an_q        <= AN_INV;
         seg_q       <= SEG_INV;
         dp_q        <= DP_INV;
         tick_q      <= 1'b0;
      end else begin
         pre_cnt_q   <= pre_cnt_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         tick_q      <= tick_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = tick_q;

endmodule
